// File: rtl/conv_pool_pkg.sv
// Shared types and constants for the conv_pool sequencer and its tag pipe.
package conv_pool_pkg;

  localparam int ADDR_W     = 16;
  localparam int NUM_BLOCKS = 65025;
  localparam int MEM_LAT    = 1;
  localparam int DP_LAT     = 3;
  localparam int LAT        = MEM_LAT + DP_LAT;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] a;
  } tag_t;

  function automatic logic [ADDR_W-1:0] clamp_blocks(input logic [ADDR_W-1:0] cfg);
    return (cfg > ADDR_W'(NUM_BLOCKS)) ? ADDR_W'(NUM_BLOCKS) : cfg;
  endfunction

endpackage

// File: rtl/conv_pool_tag_pipe.sv
// Delay line carrying {valid,addr} alongside each read request through memory and
// datapath latency, so the result write lands on the address that produced it.
module conv_pool_tag_pipe
  import conv_pool_pkg::*;
#(
  parameter int DEPTH = LAT,
  parameter int TAP   = MEM_LAT
)
(
  input  logic clk,
  input  logic rst,
  input  tag_t head,
  output logic tap_valid,
  output tag_t tail,
  output logic pending
);

  tag_t [DEPTH:1] stage;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage <= '0;
    end else begin
      stage <= {stage[DEPTH-1:1], head};
    end
  end

  assign tap_valid = stage[TAP].v;
  assign tail      = stage[DEPTH];

  // Entries in the last two stages are written by the time done is raised,
  // so only the earlier stages hold the sequencer in DRAIN.
  always_comb begin
    pending = 1'b0;
    for (int i = 1; i <= DEPTH - 2; i++) begin
      pending = pending | stage[i].v;
    end
  end

endmodule

// File: rtl/conv_pool_seq.sv
// Frame sequencer for conv_pool: issues block reads 0..n-1, tracks them through
// memory/datapath latency and raises the matching result writes, then busy/done.
module conv_pool_seq
  import conv_pool_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic [ADDR_W-1:0] cfg_num_blocks,
  output logic              busy,
  output logic              done,
  output logic              input_re,
  output logic [ADDR_W-1:0] input_addr,
  output logic              dp_in_valid,
  output logic              output_we,
  output logic [ADDR_W-1:0] output_addr
);

  seq_state_t        state;
  logic [ADDR_W-1:0] n;
  logic [ADDR_W-1:0] issue_cnt;
  logic [ADDR_W-1:0] n_clamped;
  logic              pending;
  tag_t              head;
  tag_t              tail;

  assign n_clamped   = clamp_blocks(cfg_num_blocks);
  assign input_re    = (state == RUN) && !pause;
  assign input_addr  = issue_cnt;
  assign head        = '{v: input_re, a: issue_cnt};
  assign output_we   = tail.v;
  assign output_addr = tail.a;

  conv_pool_tag_pipe #(
    .DEPTH (LAT),
    .TAP   (MEM_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .head      (head),
    .tap_valid (dp_in_valid),
    .tail      (tail),
    .pending   (pending)
  );

  // busy stays up through the done cycle, which also keeps a start pulse
  // landing on that cycle from opening a new frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      n         <= '0;
      issue_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (done) begin
        busy <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start && !busy) begin
            n         <= n_clamped;
            issue_cnt <= '0;
            busy      <= 1'b1;
            state     <= (n_clamped == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (input_re) begin
            issue_cnt <= issue_cnt + ADDR_W'(1);
            if (issue_cnt == n - ADDR_W'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!pending) begin
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
